// File: rtl/alu_pkg.sv
// Shared definitions for the alu and its operand sequencer: opcodes,
// sequencer state encoding and the default datapath width.
package alu_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic [7:0] OP_ADD = 8'd0;
    localparam logic [7:0] OP_SUB = 8'd1;
    localparam logic [7:0] OP_MUL = 8'd2;
    localparam logic [7:0] OP_EQ  = 8'd3;
    localparam logic [7:0] OP_GT  = 8'd4;
    localparam logic [7:0] OP_MOV = 8'b1011;
    // Handled inside the sequencer; the alu result is ignored for it.
    localparam logic [7:0] OP_LDI = 8'hF0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the operand sequencer: two operand read ports, one
// debug read port and one write port. r0 is a constant zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = 4,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic [AW-1:0]         raddr2,
    output logic [DATA_WIDTH-1:0] rdata2,
    input  logic [AW-1:0]         dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // r0 has no storage, so reads of it are always zero and writes vanish.
    assign regs[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        // One storage word per architectural register; cleared on reset.
        always_ff @(posedge clock_in or negedge reset_in) begin
            if (!reset_in)
                regs[i] <= '0;
            else if (we && waddr == AW'(i))
                regs[i] <= wdata;
        end
    end

    assign rdata1   = regs[raddr1];
    assign rdata2   = regs[raddr2];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_operand_sequencer.sv
// Issue stage in front of the alu: accepts one instruction per two cycles,
// fetches operands (with writeback bypass), drives the alu for one cycle,
// captures its result and retires it into the register file.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = 4,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  instr_valid_in,
    output logic                  instr_ready_out,
    input  logic [7:0]            instr_opcode_in,
    input  logic [AW-1:0]         instr_rd_in,
    input  logic [AW-1:0]         instr_rs1_in,
    input  logic [AW-1:0]         instr_rs2_in,
    input  logic [DATA_WIDTH-1:0] instr_imm_in,
    output logic                  alu_enable_out,
    output logic [7:0]            alu_opcode_out,
    output logic [DATA_WIDTH-1:0] alu_input1_out,
    output logic [DATA_WIDTH-1:0] alu_input2_out,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    output logic                  result_valid_out,
    output logic [DATA_WIDTH-1:0] result_out,
    input  logic [AW-1:0]         dbg_addr_in,
    output logic [DATA_WIDTH-1:0] dbg_data_out
);

    seq_state_t            state_q, state_d;
    logic [7:0]            opcode_q;
    logic [AW-1:0]         rd_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [DATA_WIDTH-1:0] rf_rdata1, rf_rdata2;
    logic [DATA_WIDTH-1:0] opnd1, opnd2;
    logic                  accept;
    logic                  wb_fwd_ok;

    alu_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .we       (state_q == WB),
        .waddr    (rd_q),
        .wdata    (result_q),
        .raddr1   (instr_rs1_in),
        .rdata1   (rf_rdata1),
        .raddr2   (instr_rs2_in),
        .rdata2   (rf_rdata2),
        .dbg_addr (dbg_addr_in),
        .dbg_data (dbg_data_out)
    );

    assign accept = instr_valid_in && instr_ready_out;

    // The retiring value lands in the file at the same edge a new
    // instruction samples its operands, so forward it here. r0 is never
    // forwarded because its write is dropped.
    assign wb_fwd_ok = (state_q == WB) && (rd_q != '0);
    assign opnd1 = (wb_fwd_ok && instr_rs1_in == rd_q) ? result_q : rf_rdata1;
    assign opnd2 = (wb_fwd_ok && instr_rs2_in == rd_q) ? result_q : rf_rdata2;

    // FSM state register.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state: accept in IDLE/WB starts EXEC, EXEC always retires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; ready is also held low while reset is asserted.
    always_comb begin
        instr_ready_out  = reset_in && (state_q == IDLE || state_q == WB);
        alu_enable_out   = (state_q == EXEC) && (opcode_q != OP_LDI);
        result_valid_out = (state_q == WB);
    end

    // Instruction/operand capture on accept and alu result capture in EXEC.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            opcode_q       <= '0;
            rd_q           <= '0;
            imm_q          <= '0;
            alu_opcode_out <= '0;
            alu_input1_out <= '0;
            alu_input2_out <= '0;
            result_q       <= '0;
        end else begin
            if (accept) begin
                opcode_q       <= instr_opcode_in;
                rd_q           <= instr_rd_in;
                imm_q          <= instr_imm_in;
                alu_opcode_out <= instr_opcode_in;
                alu_input1_out <= opnd1;
                alu_input2_out <= opnd2;
            end
            if (state_q == EXEC)
                result_q <= (opcode_q == OP_LDI) ? imm_q : alu_result_in;
        end
    end

    assign result_out = result_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for the operand sequencer with a behavioural alu attached
// and a reference model of the register file checking every writeback.
module tb_alu_operand_sequencer;
    import alu_pkg::*;

    localparam int DW = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [7:0]    instr_opcode = '0;
    logic [AW-1:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
    logic [DW-1:0] instr_imm = '0;
    logic          alu_en;
    logic [7:0]    alu_op;
    logic [DW-1:0] alu_a, alu_b, alu_res;
    logic          res_valid;
    logic [DW-1:0] res;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int prev_acc = 0;

    logic [DW-1:0] mregs [4];
    logic [DW-1:0] expq [$];

    alu_operand_sequencer #(.DATA_WIDTH(DW), .NUM_REGS(4)) dut (
        .clock_in         (clk),
        .reset_in         (rst_n),
        .instr_valid_in   (instr_valid),
        .instr_ready_out  (instr_ready),
        .instr_opcode_in  (instr_opcode),
        .instr_rd_in      (instr_rd),
        .instr_rs1_in     (instr_rs1),
        .instr_rs2_in     (instr_rs2),
        .instr_imm_in     (instr_imm),
        .alu_enable_out   (alu_en),
        .alu_opcode_out   (alu_op),
        .alu_input1_out   (alu_a),
        .alu_input2_out   (alu_b),
        .alu_result_in    (alu_res),
        .result_valid_out (res_valid),
        .result_out       (res),
        .dbg_addr_in      (dbg_addr),
        .dbg_data_out     (dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] alu_f(input logic [7:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return DW'(a * b);
            OP_EQ:   return {{(DW-1){1'b0}}, a == b};
            OP_GT:   return {{(DW-1){1'b0}}, $signed(a) > $signed(b)};
            OP_MOV:  return a;
            default: return '0;
        endcase
    endfunction

    // Combinational alu standing in for the real block.
    always_comb alu_res = alu_f(alu_op, alu_a, alu_b);

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Update the model, then present the instruction until it is accepted.
    task automatic issue(input logic [7:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic [DW-1:0] imm);
        logic [DW-1:0] r;
        bit ok;
        ok = 0;
        r = (op == OP_LDI) ? imm : alu_f(op, mregs[rs1], mregs[rs2]);
        if (rd != 0) mregs[rd] = r;
        expq.push_back(r);
        @(negedge clk);
        instr_opcode = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
        instr_valid = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (instr_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("accept", 8'(ok), 8'd1);
        if (ok) begin
            @(posedge clk);
            prev_acc = acc_cyc;
            acc_cyc = cyc;
        end
        #1 instr_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    task automatic dbg(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1 chk(tag, dbg_data, exp);
    endtask

    // Every writeback pulse is compared against the model in issue order.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (expq.size() == 0) chk("unexpected_pulse", 8'd1, 8'd0);
            else chk("wb_result", res, expq.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        foreach (mregs[i]) mregs[i] = '0;

        // 1: reset held three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", instr_ready, 1'b0);
        chk("rst_rvalid", res_valid, 1'b0);
        chk("rst_res", res, 8'd0);
        chk("rst_alu_en", alu_en, 1'b0);
        chk("rst_alu_a", alu_a, 8'd0);
        for (int i = 0; i < 4; i++) dbg("rst_reg", AW'(i), 8'd0);
        rst_n = 1'b1;
        #1 chk("rel_ready", instr_ready, 1'b1);

        // 2: LDI/LDI/ADD with latency check
        issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'd5);
        issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'hFD);
        issue(OP_ADD, 2'd3, 2'd1, 2'd2, 8'd0);
        @(negedge clk);
        chk("add_exec_rv", res_valid, 1'b0);
        chk("add_exec_en", alu_en, 1'b1);
        @(negedge clk);
        chk("add_wb_rv", res_valid, 1'b1);
        chk("add_wb_res", res, 8'd2);
        chk("add_wb_en", alu_en, 1'b0);
        drain();
        dbg("add_r3", 2'd3, 8'd2);

        // 3: bypass of the retiring result into the next accept
        issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'd7);
        issue(OP_ADD, 2'd2, 2'd1, 2'd1, 8'd0);
        chk("byp_gap", 8'(acc_cyc - prev_acc), 8'd2);
        drain();
        dbg("byp_r2", 2'd2, 8'd14);

        // 4: wraparound and signed compare
        issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'd127);
        issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'd1);
        issue(OP_ADD, 2'd3, 2'd1, 2'd2, 8'd0);
        drain();
        dbg("wrap_add", 2'd3, 8'h80);
        issue(OP_SUB, 2'd3, 2'd2, 2'd1, 8'd0);
        drain();
        dbg("wrap_sub", 2'd3, 8'h82);
        issue(OP_GT, 2'd3, 2'd1, 2'd2, 8'd0);
        drain();
        dbg("gt", 2'd3, 8'd1);
        issue(OP_MUL, 2'd3, 2'd1, 2'd1, 8'd0);
        drain();
        dbg("mul_wrap", 2'd3, 8'd1);

        // 5: r0 stays zero but still reports its result
        issue(OP_LDI, 2'd0, 2'd0, 2'd0, 8'd9);
        @(negedge clk);
        @(negedge clk);
        chk("r0_pulse", res_valid, 1'b1);
        chk("r0_res", res, 8'd9);
        drain();
        dbg("r0_read", 2'd0, 8'd0);
        issue(OP_MOV, 2'd1, 2'd0, 2'd0, 8'd0);
        drain();
        dbg("mov_r0", 2'd1, 8'd0);

        // 6: reset during EXEC
        issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'd5);
        issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'd3);
        drain();
        issue(OP_ADD, 2'd3, 2'd1, 2'd2, 8'd0);
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_rv", res_valid, 1'b0);
        end
        rst_n = 1'b1;
        expq.delete();
        foreach (mregs[i]) mregs[i] = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("postrst_rv", res_valid, 1'b0);
            chk("postrst_en", alu_en, 1'b0);
            chk("postrst_ready", instr_ready, 1'b1);
        end
        for (int i = 1; i < 4; i++) dbg("postrst_reg", AW'(i), 8'd0);
        issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'd4);
        issue(OP_ADD, 2'd3, 2'd2, 2'd2, 8'd0);
        drain();
        dbg("postrst_add", 2'd3, 8'd8);

        chk("queue_empty", 8'(expq.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
